// File: rtl/btb_pkg.sv
// Shared constants and types for the branch target buffer controller.
package btb_pkg;

  localparam int DEF_ENTRIES = 16;
  localparam int DEF_IDX_W   = $clog2(DEF_ENTRIES);
  localparam int DEF_ADDR_W  = 16;

  // Flush sweeper states
  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } fsm_e;

  // Counter value after reset (weakly not-taken) and on allocation (weakly taken)
  localparam logic [1:0] CTR_INIT  = 2'b01;
  localparam logic [1:0] CTR_ALLOC = 2'b10;

endpackage

// File: rtl/btb_sat_ctr.sv
// 2-bit saturating direction counter: next value from current value and outcome.
module btb_sat_ctr (
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_nxt
);

  // Step up on taken, down on not-taken, pinned at the rails
  always_comb begin
    ctr_nxt = ctr;
    if (taken) begin
      if (ctr != 2'b11) ctr_nxt = ctr + 2'b01;
    end else begin
      if (ctr != 2'b00) ctr_nxt = ctr - 2'b01;
    end
  end

endmodule

// File: rtl/btb_ctrl.sv
// Direct-mapped BTB with zero-latency lookup, EX-stage update and a
// one-entry-per-cycle flush sweeper.
module btb_ctrl
  import btb_pkg::*;
#(
  parameter int ENTRIES = DEF_ENTRIES,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_IF,
  output logic              btb_hit_IF,
  output logic [ADDR_W-1:0] btb_tgt_IF,
  input  logic              upd_vld_EX,
  input  logic [ADDR_W-1:0] upd_pc_EX,
  input  logic [ADDR_W-1:0] upd_tgt_EX,
  input  logic              upd_taken_EX,
  input  logic              flush_req,
  output logic              flush_busy
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ENTRIES - 1);

  // Table fields
  logic [ENTRIES-1:0]            valid_q;
  logic [ENTRIES-1:0][1:0]       ctr_q;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_q;
  logic [ENTRIES-1:0][ADDR_W-1:0] tgt_q;

  // Sweeper state
  fsm_e             state_q;
  logic [IDX_W-1:0] sweep_idx_q;
  logic             busy_q;

  // Lookup side
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;

  assign if_idx = pc_IF[IDX_W-1:0];
  assign if_tag = pc_IF[ADDR_W-1:IDX_W];
  // Sweep hides the table entirely; partially cleared entries must not leak
  assign if_hit = valid_q[if_idx] & (tag_q[if_idx] == if_tag) & ctr_q[if_idx][1] & ~busy_q;

  assign btb_hit_IF = if_hit;
  assign btb_tgt_IF = if_hit ? tgt_q[if_idx] : '0;
  assign flush_busy = busy_q;

  // Update side
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_match;
  logic             upd_en;
  logic [1:0]       ctr_nxt;

  assign upd_idx   = upd_pc_EX[IDX_W-1:0];
  assign upd_tag   = upd_pc_EX[ADDR_W-1:IDX_W];
  assign upd_match = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);
  // A flush request in the same cycle takes priority and drops the update
  assign upd_en    = upd_vld_EX & (state_q == IDLE) & ~flush_req;

  btb_sat_ctr u_sat_ctr (
    .ctr     (ctr_q[upd_idx]),
    .taken   (upd_taken_EX),
    .ctr_nxt (ctr_nxt)
  );

  // Sweeper FSM: walk every index once, busy flag registered alongside state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sweep_idx_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush_req) begin
            state_q     <= SWEEP;
            sweep_idx_q <= '0;
            busy_q      <= 1'b1;
          end
        end
        SWEEP: begin
          if (sweep_idx_q == IDX_LAST) begin
            state_q     <= IDLE;
            sweep_idx_q <= '0;
            busy_q      <= 1'b0;
          end else begin
            sweep_idx_q <= sweep_idx_q + IDX_ONE;
          end
        end
        default: begin
          state_q     <= IDLE;
          sweep_idx_q <= '0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Valid bits and counters: sweep clears, updates train or allocate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_INIT;
    end else if (state_q == SWEEP) begin
      valid_q[sweep_idx_q] <= 1'b0;
    end else if (upd_en) begin
      if (upd_match) begin
        ctr_q[upd_idx] <= ctr_nxt;
      end else if (upd_taken_EX) begin
        valid_q[upd_idx] <= 1'b1;
        ctr_q[upd_idx]   <= CTR_ALLOC;
      end
    end
  end

  // Tag/target payload: only meaningful under a valid bit, so no reset
  always_ff @(posedge clk) begin
    if (upd_en && upd_taken_EX) begin
      tag_q[upd_idx] <= upd_tag;
      tgt_q[upd_idx] <= upd_tgt_EX;
    end
  end

endmodule

// File: tb/tb_btb_ctrl.sv
// Self-checking bench for btb_ctrl: directed scenarios then random traffic
// against an array-based reference model.
module tb_btb_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] pc_IF;
  logic        btb_hit_IF;
  logic [15:0] btb_tgt_IF;
  logic        upd_vld_EX;
  logic [15:0] upd_pc_EX;
  logic [15:0] upd_tgt_EX;
  logic        upd_taken_EX;
  logic        flush_req;
  logic        flush_busy;

  btb_ctrl #(.ENTRIES(16), .ADDR_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_IF        (pc_IF),
    .btb_hit_IF   (btb_hit_IF),
    .btb_tgt_IF   (btb_tgt_IF),
    .upd_vld_EX   (upd_vld_EX),
    .upd_pc_EX    (upd_pc_EX),
    .upd_tgt_EX   (upd_tgt_EX),
    .upd_taken_EX (upd_taken_EX),
    .flush_req    (flush_req),
    .flush_busy   (flush_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int busy_cycles = 0;

  // Reference model: plain integers, whole-table invalidate on flush
  bit m_valid[16];
  int m_tag[16];
  int m_tgt[16];
  int m_ctr[16];
  int m_busy_left;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_busy_left = 0;
  endfunction

  function automatic bit m_hit(input logic [15:0] pc);
    int i = int'(pc) % 16;
    return (m_busy_left == 0) && m_valid[i] && (m_tag[i] == int'(pc) / 16) && (m_ctr[i] >= 2);
  endfunction

  function automatic logic [15:0] m_tgtv(input logic [15:0] pc);
    return m_hit(pc) ? 16'(m_tgt[int'(pc) % 16]) : 16'h0;
  endfunction

  function automatic void m_step();
    int i;
    int t;
    if (rst) begin
      m_reset();
      return;
    end
    if (m_busy_left > 0) begin
      m_busy_left--;
    end else if (flush_req) begin
      m_busy_left = 16;
      for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
    end else if (upd_vld_EX) begin
      i = int'(upd_pc_EX) % 16;
      t = int'(upd_pc_EX) / 16;
      if (m_valid[i] && m_tag[i] == t) begin
        if (upd_taken_EX) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = int'(upd_tgt_EX);
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (upd_taken_EX) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = t;
        m_tgt[i]   = int'(upd_tgt_EX);
        m_ctr[i]   = 2;
      end
    end
  endfunction

  // One clock: compare outputs at the falling edge, advance model at the rising edge
  task automatic tick();
    @(negedge clk);
    if (flush_busy) busy_cycles++;
    chk("hit", 32'(btb_hit_IF), 32'(m_hit(pc_IF)));
    chk("tgt", 32'(btb_tgt_IF), 32'(m_tgtv(pc_IF)));
    chk("busy", 32'(flush_busy), 32'(m_busy_left != 0));
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic upd(input logic [15:0] pc, input logic [15:0] tgt, input logic tk);
    upd_vld_EX = 1'b1; upd_pc_EX = pc; upd_tgt_EX = tgt; upd_taken_EX = tk;
    tick();
    upd_vld_EX = 1'b0;
  endtask

  task automatic look(input logic [15:0] pc);
    pc_IF = pc;
    tick();
  endtask

  initial begin
    rst = 1'b1; pc_IF = 16'h0040; upd_vld_EX = 1'b0; upd_pc_EX = '0;
    upd_tgt_EX = '0; upd_taken_EX = 1'b0; flush_req = 1'b0;
    m_reset();
    #3;
    chk("rst_hit", 32'(btb_hit_IF), 32'd0);
    chk("rst_tgt", 32'(btb_tgt_IF), 32'd0);
    chk("rst_busy", 32'(flush_busy), 32'd0);
    chk("rst_valid", 32'(dut.valid_q), 32'd0);
    chk("rst_ctr", 32'(dut.ctr_q), 32'h5555_5555);
    @(posedge clk); #1;
    rst = 1'b0;

    // Empty table miss
    look(16'h0040);

    // Allocate then hit; same index, other tag misses
    upd(16'h0043, 16'h0100, 1'b1);
    look(16'h0043);
    chk("alloc_hit", 32'(btb_hit_IF), 32'd1);
    chk("alloc_tgt", 32'(btb_tgt_IF), 32'h0100);
    look(16'h0013);
    chk("alias_miss", 32'(btb_hit_IF), 32'd0);
    chk("alloc_ctr", 32'(dut.ctr_q[3]), 32'd2);

    // Counter walk down to 00, saturate, then back up
    pc_IF = 16'h0043;
    upd(16'h0043, 16'h0000, 1'b0);
    upd(16'h0043, 16'h0000, 1'b0);
    chk("nt2_ctr", 32'(dut.ctr_q[3]), 32'd0);
    chk("nt2_hit", 32'(btb_hit_IF), 32'd0);
    chk("nt2_valid", 32'(dut.valid_q[3]), 32'd1);
    upd(16'h0043, 16'h0000, 1'b0);
    chk("nt3_ctr", 32'(dut.ctr_q[3]), 32'd0);
    upd(16'h0043, 16'h0100, 1'b1);
    chk("t1_ctr", 32'(dut.ctr_q[3]), 32'd1);
    chk("t1_hit", 32'(btb_hit_IF), 32'd0);
    upd(16'h0043, 16'h0100, 1'b1);
    chk("t2_ctr", 32'(dut.ctr_q[3]), 32'd2);
    chk("t2_hit", 32'(btb_hit_IF), 32'd1);

    // Not-taken to empty entry does nothing
    upd(16'h0055, 16'h0200, 1'b0);
    look(16'h0055);
    chk("nt_empty_valid", 32'(dut.valid_q[5]), 32'd0);

    // Full table, flush with colliding update
    for (int i = 0; i < 16; i++) upd(16'h0100 | 16'(i), 16'($urandom_range(1, 16'hffff)), 1'b1);
    pc_IF = 16'h0107;
    flush_req = 1'b1;
    upd_vld_EX = 1'b1; upd_pc_EX = 16'h0207; upd_tgt_EX = 16'h0abc; upd_taken_EX = 1'b1;
    busy_cycles = 0;
    tick();
    flush_req = 1'b0; upd_vld_EX = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pc_IF = 16'h0100 | 16'(i % 16);
      tick();
    end
    chk("busy_len", 32'(busy_cycles), 32'd16);
    chk("flush_valid", 32'(dut.valid_q), 32'd0);
    look(16'h0207);
    chk("flush_drop", 32'(btb_hit_IF), 32'd0);

    // Reset in the middle of a sweep
    for (int i = 0; i < 4; i++) upd(16'h0300 | 16'(i), 16'h0400 + 16'(i), 1'b1);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(flush_busy), 32'd0);
    chk("mid_rst_state", 32'(dut.state_q), 32'd0);
    m_reset();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      look(16'h0300 | 16'(i));
      chk("post_rst_miss", 32'(btb_hit_IF), 32'd0);
    end

    // Random traffic over a small tag space to force aliasing
    for (int n = 0; n < 800; n++) begin
      pc_IF        = 16'(($urandom_range(0, 2) << 4) | $urandom_range(0, 15));
      upd_vld_EX   = ($urandom_range(0, 3) != 0);
      upd_pc_EX    = 16'(($urandom_range(0, 2) << 4) | $urandom_range(0, 15));
      upd_tgt_EX   = 16'($urandom);
      upd_taken_EX = ($urandom_range(0, 2) != 0);
      flush_req    = ($urandom_range(0, 63) == 0);
      tick();
    end
    flush_req = 1'b0; upd_vld_EX = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
